cacheline_adapter: RTL and testbench
====================================

# cacheline_adapter

Bridges the instruction cache's 256-bit line port to the 64-bit burst memory interface. It sits directly downstream of the icache dfp port. Line fills are collected as four 64-bit read beats and returned as one 256-bit line; line writebacks are split into four consecutive 64-bit write beats. One transaction is handled at a time, with a single-cycle `dfp_resp` on completion.

## Interface
- `LINE_W`, 256: cache line width in bits.
- `BEAT_W`, 64: burst beat width. `LINE_W/BEAT_W` = 4 beats, indexed by a 2-bit counter.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `dfp_addr  in  32`: line address from the cache. Bits [4:0] are ignored.
- `dfp_read  in  1`: line fill request. Held by the cache until `dfp_resp`.
- `dfp_write  in  1`: line writeback request. Held by the cache until `dfp_resp`.
- `dfp_wdata  in  256`: writeback line. Sampled once, at acceptance.
- `dfp_rdata  out  256`: filled line. Valid in the `dfp_resp` cycle.
- `dfp_resp  out  1`: one-cycle completion pulse.
- `bmem_addr  out  32`: line-aligned burst address.
- `bmem_read  out  1`: read burst request, one cycle.
- `bmem_write  out  1`: write beat strobe, high for 4 consecutive cycles.
- `bmem_wdata  out  64`: write beat data.
- `bmem_ready  in  1`: memory can accept a new burst.
- `bmem_raddr  in  32`: address tag of the returning read beats.
- `bmem_rdata  in  64`: read beat data.
- `bmem_rvalid  in  1`: read beat valid.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, RESP. All outputs are registered.
- Reset (async, `rst_n`=0):
  - state = IDLE, beat counter = 0.
  - `dfp_resp`, `bmem_read`, `bmem_write` = 0.
  - `bmem_addr`, `bmem_wdata`, `dfp_rdata` = 0.
  - Reset mid-transaction abandons it; no `dfp_resp` is produced.
- IDLE:
  - If `dfp_write`: latch `{dfp_addr[31:5],5'b0}` and `dfp_wdata`, go to WR_REQ.
  - Else if `dfp_read`: latch the address, go to RD_REQ.
  - If both are high, write wins (writeback precedes the fill). The read stays pending and is accepted after RESP.
- RD_REQ: wait for `bmem_ready`, then drive `bmem_read`=1 and `bmem_addr` for exactly one cycle and go to RD_DATA.
- RD_DATA: each `bmem_rvalid` beat with `bmem_raddr` equal to the latched address is stored in line slice `[64*cnt +: 64]`; cnt then increments. Beat 0 is bits [63:0].
  - Beats with a mismatched address are discarded.
  - Beats arriving in any state other than RD_DATA are discarded.
  - After the 4th beat (cnt wraps 3 to 0), go to RESP.
- WR_REQ: wait for `bmem_ready`, then go to WR_DATA.
- WR_DATA:
  - `bmem_write`=1 for 4 consecutive cycles. Each cycle, `bmem_addr` = latched address and `bmem_wdata` = slice `cnt`, with beat 0 first.
  - Subsequent beats do not check `bmem_ready` (memory contract).
  - After beat 3, go to RESP.
- RESP:
  - `dfp_resp`=1 for one cycle. `dfp_rdata` holds the assembled line for reads and the last read line for writes.
  - Next state is IDLE.
  - A request still asserted in IDLE is treated as new; the cache deasserts the cycle after `dfp_resp`.
- `dfp_*` inputs are ignored outside IDLE.

## Timing
- Read, request seen in IDLE at cycle T with `bmem_ready`=1:
  - `bmem_read` high at T+2.
  - With beats arriving on cycles R0..R3, `dfp_resp` is high at R3+1.
  - Minimum latency with back-to-back beats starting at T+3 is T+7.
- Write, request seen at T with `bmem_ready`=1: `bmem_write` high at T+2..T+5, `dfp_resp` at T+6.
- `bmem_ready` low delays the burst by one cycle per low cycle. No output toggles while waiting.
- Gaps in `bmem_rvalid` are permitted; the counter advances only on accepted beats.
- Never more than one outstanding burst.

## Test plan
- Read fill: `dfp_read`, `dfp_addr`=0x0000_1234. Expect `bmem_addr`=0x0000_1220 and a single `bmem_read` pulse. Return beats 0x11..11, 0x22..22, 0x33..33, 0x44..44. Expect `dfp_resp` for exactly one cycle with `dfp_rdata`={0x44..,0x33..,0x22..,0x11..}.
- Writeback: `dfp_write`, addr 0x8000_0040, wdata = 4 distinct beats. Expect 4 consecutive `bmem_write` cycles emitting beat0..beat3 in order, then `dfp_resp` exactly one cycle later.
- Read and write simultaneous: write burst first, then `dfp_resp`. Read is accepted the cycle after, with its own `bmem_read` and its own `dfp_resp`.
- `bmem_ready` held low 5 cycles after acceptance: no `bmem_read` until ready rises. Read beats with gaps, plus one stray beat with `bmem_raddr` mismatched, still produce the correct line with only 4 beats counted.
- `rst_n` asserted after 2 of 4 read beats: all outputs are 0 immediately. A subsequent fresh read completes correctly; leftover beats arriving in IDLE are ignored.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
// Signal bundle between the icache line port (dfp_*) and the 64-bit burst memory (bmem_*).
// The adapter connects through the slave modport; the cache/memory side uses master.
interface cacheline_adapter_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic [31:0]       dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;

    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts 256-bit icache line fills/writebacks into 64-bit burst beats, one
// transaction at a time, with a registered single-cycle dfp_resp on completion.
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    cacheline_adapter_if.slave bus
);
    localparam int N_BEATS = LINE_W / BEAT_W;
    localparam int CNT_W   = $clog2(N_BEATS);
    localparam logic [31:0]      OFF_MASK = 32'((LINE_W / 8) - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BEATS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    logic [2:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       addr_r;
    logic [LINE_W-1:0] wline_r;
    logic [LINE_W-1:0] line_r;
    logic [31:0]       bmem_addr_r;
    logic [BEAT_W-1:0] bmem_wdata_r;
    logic              bmem_read_r;
    logic              bmem_write_r;
    logic              dfp_resp_r;

    logic [31:0]       req_addr_s;
    logic              beat_hit_s;
    logic [BEAT_W-1:0] wr_beat_s;

    function automatic logic [BEAT_W-1:0] beat_sel(
        input logic [LINE_W-1:0] line,
        input logic [CNT_W-1:0]  idx
    );
        return line[int'(idx) * BEAT_W +: BEAT_W];
    endfunction

    // Aligned request address, read-beat acceptance and current write slice.
    always_comb begin
        req_addr_s = bus.dfp_addr & ~OFF_MASK;
        beat_hit_s = bus.bmem_rvalid && (bus.bmem_raddr == addr_r);
        wr_beat_s  = beat_sel(wline_r, cnt_r);
    end

    // Transaction FSM with registered bus outputs and line assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            addr_r       <= 32'h0;
            wline_r      <= {LINE_W{1'b0}};
            line_r       <= {LINE_W{1'b0}};
            bmem_addr_r  <= 32'h0;
            bmem_wdata_r <= {BEAT_W{1'b0}};
            bmem_read_r  <= 1'b0;
            bmem_write_r <= 1'b0;
            dfp_resp_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dfp_resp_r <= 1'b0;
                    // Writeback wins so a dirty victim leaves before its fill arrives.
                    if (bus.dfp_write) begin
                        addr_r  <= req_addr_s;
                        wline_r <= bus.dfp_wdata;
                        state_r <= WR_REQ;
                    end else if (bus.dfp_read) begin
                        addr_r  <= req_addr_s;
                        state_r <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bus.bmem_ready) begin
                        bmem_read_r <= 1'b1;
                        bmem_addr_r <= addr_r;
                        state_r     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    bmem_read_r <= 1'b0;
                    if (beat_hit_s) begin
                        line_r[int'(cnt_r) * BEAT_W +: BEAT_W] <= bus.bmem_rdata;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            dfp_resp_r <= 1'b1;
                            state_r    <= RESP;
                        end
                    end
                end
                WR_REQ: begin
                    if (bus.bmem_ready) begin
                        bmem_write_r <= 1'b1;
                        bmem_addr_r  <= addr_r;
                        bmem_wdata_r <= wr_beat_s;
                        cnt_r        <= cnt_r + CNT_ONE;
                        state_r      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    // cnt_r names the next beat to emit; wrapping to zero means the last one is on the bus.
                    if (cnt_r == CNT_ZERO) begin
                        bmem_write_r <= 1'b0;
                        dfp_resp_r   <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        bmem_wdata_r <= wr_beat_s;
                        cnt_r        <= cnt_r + CNT_ONE;
                    end
                end
                RESP: begin
                    dfp_resp_r <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= CNT_ZERO;
                    bmem_read_r  <= 1'b0;
                    bmem_write_r <= 1'b0;
                    dfp_resp_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dfp_rdata  = line_r;
    assign bus.dfp_resp   = dfp_resp_r;
    assign bus.bmem_addr  = bmem_addr_r;
    assign bus.bmem_read  = bmem_read_r;
    assign bus.bmem_write = bmem_write_r;
    assign bus.bmem_wdata = bmem_wdata_r;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Table-driven bench for cacheline_adapter: a behavioural cache/memory driver plus a
// scoreboard of expected read requests, write beats and response lines.
module tb_cacheline_adapter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    cacheline_adapter_if #(.LINE_W(256), .BEAT_W(64)) bus ();

    cacheline_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;
        int           rdy_dly;
        int           gap;
        logic         stray;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t vecs[5];

    logic [31:0]  rd_q[$];
    logic [95:0]  wr_q[$];
    logic [255:0] resp_q[$];
    logic [255:0] last_rline = 256'h0;
    logic         prev_rd = 1'b0;
    logic         prev_resp = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: output with no expectation queued (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: every bus event the DUT produces is matched against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bmem_read) begin
                chk("rd_pulse", 256'(prev_rd), 256'(1'b0));
                if (rd_q.size() == 0) unexpected("rd_unexpected");
                else chk("rd_addr", 256'(bus.bmem_addr), 256'(rd_q.pop_front()));
            end
            if (bus.bmem_write) begin
                if (wr_q.size() == 0) unexpected("wr_unexpected");
                else chk("wr_beat", 256'({bus.bmem_addr, bus.bmem_wdata}), 256'(wr_q.pop_front()));
            end
            if (bus.dfp_resp) begin
                chk("resp_pulse", 256'(prev_resp), 256'(1'b0));
                if (resp_q.size() == 0) unexpected("resp_unexpected");
                else chk("resp_rdata", bus.dfp_rdata, resp_q.pop_front());
            end
        end
        prev_rd   <= bus.bmem_read;
        prev_resp <= bus.dfp_resp;
    end

    task automatic wait_for(input int sel, output int at);
        at = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if ((sel == 0 && bus.bmem_read) || (sel == 1 && bus.bmem_write)) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic serve_read(input logic [31:0] a, input logic [255:0] line,
                              input int gap, input logic stray);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.bmem_rvalid = 1'b0;
                end
            end
            if (stray && i == 2) begin
                @(negedge clk);
                bus.bmem_rvalid = 1'b1;
                bus.bmem_raddr  = a ^ 32'h0000_0100;
                bus.bmem_rdata  = ~line[64*i +: 64];
            end
            @(negedge clk);
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = a;
            bus.bmem_rdata  = line[64*i +: 64];
        end
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
    endtask

    task automatic wr_tail();
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("wr_burst", 256'(bus.bmem_write), 256'(1'b1));
        end
        @(negedge clk);
        chk("wr_resp", 256'({bus.bmem_write, bus.dfp_resp}), 256'(2'b01));
    endtask

    task automatic run_vec(input vec_t v);
        int t, at;
        @(negedge clk);
        t = cyc;
        bus.bmem_ready = (v.rdy_dly == 0);
        bus.dfp_addr   = v.addr;
        bus.dfp_wdata  = v.wr ? v.line : ~v.line;
        bus.dfp_write  = v.wr;
        bus.dfp_read   = ~v.wr;
        if (v.wr) begin
            for (int i = 0; i < 4; i++) wr_q.push_back({v.exp_addr, v.line[64*i +: 64]});
            resp_q.push_back(last_rline);
        end else begin
            rd_q.push_back(v.exp_addr);
            resp_q.push_back(v.line);
            last_rline = v.line;
        end
        if (v.rdy_dly > 0) begin
            for (int k = 1; k <= v.rdy_dly + 1; k++) begin
                @(negedge clk);
                chk("stall_quiet", 256'({bus.bmem_read, bus.bmem_write, bus.dfp_resp}), 256'(3'b000));
            end
            bus.bmem_ready = 1'b1;
        end
        if (v.wr) begin
            wait_for(1, at);
            chk_int("wr_start", at, t + 2 + v.rdy_dly);
            wr_tail();
        end else begin
            wait_for(0, at);
            chk_int("rd_start", at, t + 2 + v.rdy_dly);
            serve_read(v.exp_addr, v.line, v.gap, v.stray);
            chk("rd_resp", 256'(bus.dfp_resp), 256'(1'b1));
        end
        bus.dfp_read  = 1'b0;
        bus.dfp_write = 1'b0;
        @(negedge clk);
        chk("resp_single", 256'(bus.dfp_resp), 256'(1'b0));
    endtask

    task automatic seq_simul();
        int t, at;
        logic [255:0] lw, lr;
        lw = {64'h0B0B_0B0B_0000_0003, 64'h0A0A_0A0A_0000_0002, 64'h0909_0909_0000_0001, 64'h0808_0808_0000_0000};
        lr = {64'h7777_0000_7777_0003, 64'h6666_0000_6666_0002, 64'h5555_0000_5555_0001, 64'h4444_0000_4444_0000};
        @(negedge clk);
        t = cyc;
        bus.bmem_ready = 1'b1;
        bus.dfp_addr   = 32'h0000_041C;
        bus.dfp_wdata  = lw;
        bus.dfp_write  = 1'b1;
        bus.dfp_read   = 1'b1;
        for (int i = 0; i < 4; i++) wr_q.push_back({32'h0000_0400, lw[64*i +: 64]});
        resp_q.push_back(last_rline);
        rd_q.push_back(32'h0000_0800);
        resp_q.push_back(lr);
        last_rline = lr;
        wait_for(1, at);
        chk_int("sim_wr_start", at, t + 2);
        wr_tail();
        bus.dfp_write = 1'b0;
        bus.dfp_addr  = 32'h0000_0817;
        @(negedge clk);
        chk("sim_resp_single", 256'({bus.dfp_resp, bus.bmem_read}), 256'(2'b00));
        wait_for(0, at);
        chk_int("sim_rd_start", at, t + 9);
        serve_read(32'h0000_0800, lr, 0, 1'b0);
        chk("sim_rd_resp", 256'(bus.dfp_resp), 256'(1'b1));
        bus.dfp_read = 1'b0;
        @(negedge clk);
        chk("sim_rd_single", 256'(bus.dfp_resp), 256'(1'b0));
    endtask

    task automatic seq_reset();
        int t, at;
        logic [255:0] l1, l2;
        l1 = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        l2 = {64'hBBBB_1111_2222_0003, 64'hBBBB_1111_2222_0002, 64'hBBBB_1111_2222_0001, 64'hBBBB_1111_2222_0000};
        @(negedge clk);
        bus.bmem_ready = 1'b1;
        bus.dfp_addr   = 32'h0000_2000;
        bus.dfp_read   = 1'b1;
        rd_q.push_back(32'h0000_2000);
        wait_for(0, at);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = 32'h0000_2000;
            bus.bmem_rdata  = l1[64*i +: 64];
        end
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 256'({bus.dfp_resp, bus.bmem_read, bus.bmem_write}), 256'(3'b000));
        chk("mid_rst_addr", 256'(bus.bmem_addr), 256'(32'h0));
        chk("mid_rst_wdata", 256'(bus.bmem_wdata), 256'(64'h0));
        chk("mid_rst_rdata", bus.dfp_rdata, 256'h0);
        bus.dfp_read = 1'b0;
        last_rline = 256'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Leftover beats of the abandoned burst while idle must be ignored.
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = 32'h0000_2000;
            bus.bmem_rdata  = l1[64*i +: 64];
        end
        @(negedge clk);
        t = cyc;
        bus.bmem_rvalid = 1'b0;
        bus.bmem_ready  = 1'b0;
        bus.dfp_addr    = 32'h0000_3011;
        bus.dfp_read    = 1'b1;
        rd_q.push_back(32'h0000_3000);
        resp_q.push_back(l2);
        last_rline = l2;
        @(negedge clk);
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = 32'h0000_3000;
        bus.bmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        bus.bmem_ready  = 1'b1;
        wait_for(0, at);
        chk_int("rst_rd_start", at, t + 3);
        serve_read(32'h0000_3000, l2, 0, 1'b0);
        chk("rst_rd_resp", 256'(bus.dfp_resp), 256'(1'b1));
        bus.dfp_read = 1'b0;
        @(negedge clk);
        chk("rst_rd_single", 256'(bus.dfp_resp), 256'(1'b0));
    endtask

    initial begin
        vecs[0] = '{wr: 1'b0, addr: 32'h0000_1234,
                    line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    rdy_dly: 0, gap: 0, stray: 1'b0, exp_addr: 32'h0000_1220};
        vecs[1] = '{wr: 1'b1, addr: 32'h8000_0040,
                    line: {64'h1357_9BDF_2468_ACE0, 64'hA5A5_5A5A_0F0F_F0F0,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                    rdy_dly: 0, gap: 0, stray: 1'b0, exp_addr: 32'h8000_0040};
        vecs[2] = '{wr: 1'b0, addr: 32'h0000_BEEF,
                    line: {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                           64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001},
                    rdy_dly: 5, gap: 2, stray: 1'b1, exp_addr: 32'h0000_BEE0};
        vecs[3] = '{wr: 1'b1, addr: 32'hFFFF_FFFF,
                    line: {64'h4040_4040_4040_4040, 64'h3030_3030_3030_3030,
                           64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010},
                    rdy_dly: 2, gap: 0, stray: 1'b0, exp_addr: 32'hFFFF_FFE0};
        vecs[4] = '{wr: 1'b0, addr: 32'hDEAD_BEA5,
                    line: {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222,
                           64'h1111_0000_FFFF_EEEE, 64'hDDDD_CCCC_BBBB_AAAA},
                    rdy_dly: 1, gap: 1, stray: 1'b1, exp_addr: 32'hDEAD_BEA0};

        bus.dfp_addr    = 32'h0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = 256'h0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_raddr  = 32'h0;
        bus.bmem_rdata  = 64'h0;
        bus.bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 256'({bus.dfp_resp, bus.bmem_read, bus.bmem_write}), 256'(3'b000));
        chk("rst_addr", 256'(bus.bmem_addr), 256'(32'h0));
        chk("rst_wdata", 256'(bus.bmem_wdata), 256'(64'h0));
        chk("rst_rdata", bus.dfp_rdata, 256'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        seq_simul();
        seq_reset();

        repeat (4) @(negedge clk);
        chk_int("rd_q_empty", rd_q.size(), 0);
        chk_int("wr_q_empty", wr_q.size(), 0);
        chk_int("resp_q_empty", resp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
